// File: rtl/axi_pkg.sv
// AXI4 read-side types and burst address helpers shared by the read responder
// and its address generator.
package axi_pkg;

    localparam int AXI_MAX_ADDR_W = 64;
    localparam int AXI_MAX_ID_W   = 16;

    typedef enum logic [2:0] {
        SIZE_1   = 3'd0,
        SIZE_2   = 3'd1,
        SIZE_4   = 3'd2,
        SIZE_8   = 3'd3,
        SIZE_16  = 3'd4,
        SIZE_32  = 3'd5,
        SIZE_64  = 3'd6,
        SIZE_128 = 3'd7
    } AxiSize_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } AxiBurst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } AxiResp_t;

    // Widths are sized for the largest supported bus; users cast down to their own widths.
    typedef struct packed {
        logic [AXI_MAX_ADDR_W-1:0] addr;
        logic [7:0]                len;
        AxiSize_t                  size;
        AxiBurst_t                 burst;
        logic [AXI_MAX_ID_W-1:0]   id;
    } AxiBurstCmd_t;

    function automatic logic axiWrapLenOk(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [AXI_MAX_ADDR_W-1:0] axiNextAddr(
        input logic [AXI_MAX_ADDR_W-1:0] addr,
        input AxiSize_t                  size,
        input AxiBurst_t                 burst,
        input logic [7:0]                len
    );
        logic [AXI_MAX_ADDR_W-1:0] bytes;
        logic [AXI_MAX_ADDR_W-1:0] span;
        logic [AXI_MAX_ADDR_W-1:0] lower;
        logic [AXI_MAX_ADDR_W-1:0] nxt;
        bytes = 64'd1 << size;
        span  = bytes * ({56'd0, len} + 64'd1);
        lower = addr & ~(span - 64'd1);
        case (burst)
            BURST_INCR: nxt = (addr & ~(bytes - 64'd1)) + bytes;
            BURST_WRAP: begin
                nxt = addr + bytes;
                if (nxt == lower + span) begin
                    nxt = lower;
                end
            end
            default:    nxt = addr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address and beat counter for one AXI read burst: load on AR accept,
// advance on each non-final R handshake.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load,
    input  logic                      i_advance,
    input  AxiBurstCmd_t              i_cmd,
    output logic [AXI_MAX_ADDR_W-1:0] o_cur_addr,
    output logic [AXI_MAX_ID_W-1:0]   o_id,
    output logic                      o_last
);

    // Keeps address arithmetic modulo the real bus width.
    localparam logic [AXI_MAX_ADDR_W-1:0] ADDR_MASK =
        (ADDR_W >= AXI_MAX_ADDR_W) ? '1 : ((64'd1 << ADDR_W) - 64'd1);

    logic [AXI_MAX_ADDR_W-1:0] r_cur_addr;
    logic [7:0]                r_beat_cnt;
    logic [7:0]                r_len;
    AxiSize_t                  r_size;
    AxiBurst_t                 r_burst;
    logic [AXI_MAX_ID_W-1:0]   r_id;
    logic [AXI_MAX_ADDR_W-1:0] w_next_addr;

    assign w_next_addr = axiNextAddr(r_cur_addr, r_size, r_burst, r_len) & ADDR_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr <= '0;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_size     <= SIZE_1;
            r_burst    <= BURST_FIXED;
            r_id       <= '0;
        end else if (i_load) begin
            r_cur_addr <= i_cmd.addr & ADDR_MASK;
            r_beat_cnt <= '0;
            r_len      <= i_cmd.len;
            r_size     <= i_cmd.size;
            r_burst    <= i_cmd.burst;
            r_id       <= i_cmd.id;
        end else if (i_advance) begin
            r_cur_addr <= w_next_addr;
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    assign o_cur_addr = r_cur_addr;
    assign o_id       = r_id;
    assign o_last     = (r_beat_cnt == r_len);

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read responder: one burst at a time, each beat fetched from a 1-cycle
// synchronous memory and returned on R with OKAY or SLVERR.
module axi_rd_slave
    import axi_pkg::*;
#(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int ID_W      = 4,
    parameter  int MEM_BYTES = 4096,
    localparam int AW_MEM    = $clog2(MEM_BYTES / (DATA_W / 8))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  AxiSize_t          s_arsize,
    input  AxiBurst_t         s_arburst,
    input  logic [ID_W-1:0]   s_arid,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [DATA_W-1:0] s_rdata,
    output AxiResp_t          s_rresp,
    output logic              s_rlast,
    output logic [ID_W-1:0]   s_rid,
    output logic              mem_rd,
    output logic [AW_MEM-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int         LANE_W   = $clog2(DATA_W / 8);
    localparam logic [2:0] MAX_SIZE = 3'(LANE_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic                      r_arready;
    logic                      r_fresh;
    logic                      r_burst_err;
    logic [DATA_W-1:0]         r_rdata;
    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_last;
    logic                      w_beat_err;
    logic                      w_ar_err;
    logic                      w_wrap_err;
    logic [AXI_MAX_ADDR_W-1:0] w_ar_bytes;
    logic [AXI_MAX_ADDR_W-1:0] w_cur_addr;
    logic [AXI_MAX_ID_W-1:0]   w_id;
    logic [DATA_W-1:0]         w_beat_data;
    AxiBurstCmd_t              w_cmd;

    always_comb begin
        w_cmd       = '0;
        w_cmd.addr  = AXI_MAX_ADDR_W'(s_araddr);
        w_cmd.len   = s_arlen;
        w_cmd.size  = s_arsize;
        w_cmd.burst = s_arburst;
        w_cmd.id    = AXI_MAX_ID_W'(s_arid);
    end

    // Whole-burst errors are decided once at AR accept and poison every beat.
    assign w_ar_bytes = 64'd1 << s_arsize;
    assign w_wrap_err = (s_arburst == BURST_WRAP) &&
                        (!axiWrapLenOk(s_arlen) || ((w_cmd.addr & (w_ar_bytes - 64'd1)) != '0));
    assign w_ar_err   = (s_arsize > MAX_SIZE) || (s_arburst == BURST_RSVD) || w_wrap_err;

    assign w_ar_hs    = s_arvalid && s_arready;
    assign w_r_hs     = s_rvalid && s_rready;
    assign w_beat_err = r_burst_err || (w_cur_addr >= AXI_MAX_ADDR_W'(MEM_BYTES));
    assign w_beat_data = w_beat_err ? '0 : mem_rdata;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ar_hs),
        .i_advance  (w_r_hs && !w_last),
        .i_cmd      (w_cmd),
        .o_cur_addr (w_cur_addr),
        .o_id       (w_id),
        .o_last     (w_last)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_ar_hs) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = ST_DATA;
            ST_DATA:  if (w_r_hs) w_next_state = w_last ? ST_IDLE : ST_FETCH;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Memory data is only valid in the first DATA cycle, so it is registered there for stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_arready   <= 1'b0;
            r_fresh     <= 1'b0;
            r_rdata     <= '0;
            r_burst_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_arready <= (w_next_state == ST_IDLE);
            r_fresh   <= (r_state == ST_FETCH);
            if (r_fresh) begin
                r_rdata <= w_beat_data;
            end
            if (w_ar_hs) begin
                r_burst_err <= w_ar_err;
            end
        end
    end

    assign s_arready = r_arready;
    assign s_rvalid  = (r_state == ST_DATA);
    assign s_rlast   = s_rvalid && w_last;
    assign s_rresp   = (s_rvalid && w_beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_rdata   = r_fresh ? w_beat_data : r_rdata;
    assign s_rid     = ID_W'(w_id);
    assign mem_rd    = (r_state == ST_FETCH) && !w_beat_err;
    assign mem_addr  = w_cur_addr[LANE_W +: AW_MEM];

endmodule

// File: tb/tb_axi_rd_slave.sv
// Self-checking bench for axi_rd_slave: a scoreboard of expected R beats and
// memory word reads is filled from an address model before each burst is issued.
module tb_axi_rd_slave;
    import axi_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int MEM_BYTES = 4096;
    localparam int AW_MEM    = 10;

    typedef struct {
        logic [DATA_W-1:0] data;
        AxiResp_t          resp;
        logic              last;
        logic [ID_W-1:0]   id;
    } ExpBeat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_arvalid = 1'b0;
    logic              s_arready;
    logic [ADDR_W-1:0] s_araddr = '0;
    logic [7:0]        s_arlen = '0;
    AxiSize_t          s_arsize = SIZE_4;
    AxiBurst_t         s_arburst = BURST_INCR;
    logic [ID_W-1:0]   s_arid = '0;
    logic              s_rvalid;
    logic              s_rready = 1'b0;
    logic [DATA_W-1:0] s_rdata;
    AxiResp_t          s_rresp;
    logic              s_rlast;
    logic [ID_W-1:0]   s_rid;
    logic              mem_rd;
    logic [AW_MEM-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    ExpBeat_t          expQ[$];
    logic [AW_MEM-1:0] expMemAddr[$];
    logic [AW_MEM-1:0] memAddrLog[$];

    axi_rd_slave #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ID_W      (ID_W),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arid    (s_arid),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rid     (s_rid),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] memWord(input logic [AW_MEM-1:0] idx);
        return {16'hA5C3, 6'd0, idx};
    endfunction

    // Memory returns data one cycle after the strobe and garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd === 1'b1) begin
            mem_rdata <= memWord(mem_addr);
            memAddrLog.push_back(mem_addr);
        end else begin
            mem_rdata <= 32'hDEADBEEF;
        end
    end

    function automatic logic [31:0] modelAddr(input logic [31:0] base, input logic [7:0] len,
                                              input AxiSize_t size, input AxiBurst_t burst, input int k);
        logic [31:0] b;
        logic [31:0] total;
        logic [31:0] lower;
        b     = 32'd1 << size;
        total = b * (32'(len) + 32'd1);
        lower = base & ~(total - 32'd1);
        case (burst)
            BURST_FIXED: return base;
            BURST_INCR:  return (k == 0) ? base : ((base & ~(b - 32'd1)) + b * 32'(k));
            default:     return lower + ((base - lower + b * 32'(k)) % total);
        endcase
    endfunction

    function automatic bit modelBurstErr(input logic [31:0] base, input logic [7:0] len,
                                         input AxiSize_t size, input AxiBurst_t burst);
        bit wrapLenBad;
        wrapLenBad = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (32'(size) > 32'd2) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && (wrapLenBad || ((base % (32'd1 << size)) != 32'd0)));
    endfunction

    task automatic runBurst(input logic [31:0] base, input logic [7:0] len, input AxiSize_t size,
                            input AxiBurst_t burst, input logic [ID_W-1:0] id,
                            input int stallBeat, input int stallCycles, input string tag);
        logic [31:0] a;
        bit          bErr;
        bit          beatErr;
        int          n;
        ExpBeat_t    e;
        bErr = modelBurstErr(base, len, size, burst);
        expQ.delete();
        expMemAddr.delete();
        for (int k = 0; k <= int'(len); k++) begin
            a       = modelAddr(base, len, size, burst, k);
            beatErr = bErr || (a >= 32'(MEM_BYTES));
            e.data  = beatErr ? '0 : memWord(a[11:2]);
            e.resp  = beatErr ? RESP_SLVERR : RESP_OKAY;
            e.last  = (k == int'(len));
            e.id    = id;
            expQ.push_back(e);
            if (!beatErr) expMemAddr.push_back(a[11:2]);
        end
        memAddrLog.delete();
        @(negedge clk);
        s_arvalid = 1'b1;
        s_araddr  = base;
        s_arlen   = len;
        s_arsize  = size;
        s_arburst = burst;
        s_arid    = id;
        n = 0;
        while (s_arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ar_accept: arready=%b required 1", tag, s_arready);
            s_arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            s_rready = (k == stallBeat) ? 1'b0 : 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (s_rvalid !== 1'b1 && n < 10);
            e = expQ.pop_front();
            checks++;
            if (s_rvalid !== 1'b1 || n != 2) begin
                errors++;
                $display("[TB] FAIL %s beat%0d latency: rvalid=%b after %0d cycles, required 1 after 2", tag, k, s_rvalid, n);
                s_rready = 1'b1;
                return;
            end
            checks++;
            if (s_rdata !== e.data) begin
                errors++;
                $display("[TB] FAIL %s beat%0d rdata: got %h required %h", tag, k, s_rdata, e.data);
            end
            checks++;
            if (s_rresp !== e.resp) begin
                errors++;
                $display("[TB] FAIL %s beat%0d rresp: got %0d required %0d", tag, k, s_rresp, e.resp);
            end
            checks++;
            if (s_rlast !== e.last) begin
                errors++;
                $display("[TB] FAIL %s beat%0d rlast: got %b required %b", tag, k, s_rlast, e.last);
            end
            checks++;
            if (s_rid !== e.id) begin
                errors++;
                $display("[TB] FAIL %s beat%0d rid: got %h required %h", tag, k, s_rid, e.id);
            end
            if (k == stallBeat) begin
                for (int i = 0; i < stallCycles; i++) begin
                    @(negedge clk);
                    checks++;
                    if (s_rvalid !== 1'b1 || s_rdata !== e.data || s_rresp !== e.resp || s_rlast !== e.last) begin
                        errors++;
                        $display("[TB] FAIL %s stall%0d: valid=%b data=%h resp=%0d last=%b required 1 %h %0d %b",
                                 tag, i, s_rvalid, s_rdata, s_rresp, s_rlast, e.data, e.resp, e.last);
                    end
                end
                s_rready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (s_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s arready_after_last: got %b required 1", tag, s_arready);
        end
        checks++;
        if (memAddrLog.size() != expMemAddr.size()) begin
            errors++;
            $display("[TB] FAIL %s mem_rd_count: got %0d required %0d", tag, memAddrLog.size(), expMemAddr.size());
        end else begin
            foreach (expMemAddr[i]) begin
                checks++;
                if (memAddrLog[i] !== expMemAddr[i]) begin
                    errors++;
                    $display("[TB] FAIL %s mem_addr%0d: got %0d required %0d", tag, i, memAddrLog[i], expMemAddr[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s_arready !== 1'b0 || s_rvalid !== 1'b0 || s_rlast !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: arready=%b rvalid=%b rlast=%b mem_rd=%b required all 0",
                     s_arready, s_rvalid, s_rlast, mem_rd);
        end
        checks++;
        if (s_rresp !== RESP_OKAY || s_rdata !== '0 || s_rid !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: rresp=%0d rdata=%h rid=%h required 0 0 0", s_rresp, s_rdata, s_rid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_arready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_arready: got %b required 1", s_arready);
        end
    endtask

    task automatic test_incr();
        runBurst(32'h10, 8'd3, SIZE_4, BURST_INCR, 4'd5, -1, 0, "incr");
        runBurst(32'h13, 8'd3, SIZE_1, BURST_INCR, 4'd2, -1, 0, "incr_narrow");
        runBurst(32'h84, 8'd0, SIZE_4, BURST_INCR, 4'hF, -1, 0, "single_beat");
    endtask

    task automatic test_wrap();
        runBurst(32'h38, 8'd3, SIZE_4, BURST_WRAP, 4'd6, -1, 0, "wrap");
        runBurst(32'h1E, 8'd7, SIZE_2, BURST_WRAP, 4'd1, -1, 0, "wrap_half");
    endtask

    task automatic test_fixed_stall();
        runBurst(32'h20, 8'd2, SIZE_4, BURST_FIXED, 4'd7, 1, 5, "fixed_stall");
    endtask

    task automatic test_top_boundary();
        runBurst(32'(MEM_BYTES - 8), 8'd3, SIZE_4, BURST_INCR, 4'd3, -1, 0, "incr_top");
    endtask

    task automatic test_burst_errors();
        runBurst(32'h40, 8'd1, SIZE_8, BURST_INCR, 4'd8, -1, 0, "err_size");
        runBurst(32'h40, 8'd2, SIZE_4, BURST_WRAP, 4'd9, -1, 0, "err_wrap_len");
        runBurst(32'h3A, 8'd3, SIZE_4, BURST_WRAP, 4'd4, -1, 0, "err_wrap_align");
        runBurst(32'h00, 8'd0, SIZE_4, BURST_RSVD, 4'd2, -1, 0, "err_rsvd");
    endtask

    task automatic test_reset_mid_burst();
        int n;
        @(negedge clk);
        s_arvalid = 1'b1;
        s_araddr  = 32'h100;
        s_arlen   = 8'd7;
        s_arsize  = SIZE_4;
        s_arburst = BURST_INCR;
        s_arid    = 4'hA;
        s_rready  = 1'b1;
        n = 0;
        while (s_arready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_rready = (k == 0);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (s_rvalid !== 1'b1 && n < 10);
            checks++;
            if (s_rvalid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rst_mid beat%0d: rvalid=%b required 1", k, s_rvalid);
            end
            if (k == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_abort: rvalid=%b arready=%b mem_rd=%b required 0 0 0", s_rvalid, s_arready, mem_rd);
        end
        @(negedge clk);
        rst = 1'b0;
        s_rready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rst_mid_idle: rvalid=%b arready=%b required 0 1", s_rvalid, s_arready);
            end
        end
        runBurst(32'h40, 8'd1, SIZE_4, BURST_INCR, 4'd3, -1, 0, "after_rst");
    endtask

    task automatic test_back_to_back();
        runBurst(32'h200, 8'd1, SIZE_4, BURST_INCR, 4'd1, -1, 0, "b2b_a");
        runBurst(32'h300, 8'd2, SIZE_4, BURST_INCR, 4'd2, 0, 2, "b2b_b");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_stall();
        test_top_boundary();
        test_burst_errors();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
